// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB stage bus: upstream beat (in_*), downstream beat (out_*) and occupancy.
// The slave modport is the stage; the master modport is the environment around it.
interface mem_wb_skid_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_cal;
  logic [DW-1:0] in_rd;
  logic [AW-1:0] in_wn;
  logic          in_regwrite;
  logic          in_memtoreg;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_cal;
  logic [DW-1:0] out_rd;
  logic [AW-1:0] out_wn;
  logic          out_regwrite;
  logic          out_memtoreg;
  logic [DW-1:0] out_wb_data;
  logic [1:0]    occupancy;

  modport slave (
    input  in_valid, in_cal, in_rd, in_wn, in_regwrite, in_memtoreg,
    output in_ready,
    input  out_ready,
    output out_valid, out_cal, out_rd, out_wn, out_regwrite, out_memtoreg,
    output out_wb_data, occupancy
  );

  modport master (
    output in_valid, in_cal, in_rd, in_wn, in_regwrite, in_memtoreg,
    input  in_ready,
    output out_ready,
    input  out_valid, out_cal, out_rd, out_wn, out_regwrite, out_memtoreg,
    input  out_wb_data, occupancy
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush, $zero write gating and
// a registered writeback-data mux. in_ready depends only on local state, never on out_ready.
module mem_wb_skid_stage #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter bit ZERO_GATE = 1'b1
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  mem_wb_skid_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0] cal;
    logic [DW-1:0] rd;
    logic [AW-1:0] wn;
    logic          regwrite;
    logic          memtoreg;
    logic [DW-1:0] wb_data;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  // Gating and the writeback mux are resolved once, when a beat is captured.
  always_comb begin
    in_entry.cal      = bus.in_cal;
    in_entry.rd       = bus.in_rd;
    in_entry.wn       = bus.in_wn;
    in_entry.regwrite = bus.in_regwrite & ~(ZERO_GATE & (bus.in_wn == '0));
    in_entry.memtoreg = bus.in_memtoreg;
    in_entry.wb_data  = bus.in_memtoreg ? bus.in_rd : bus.in_cal;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = HALF;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Payload may pick up the dropped beat; it stays invisible because state is EMPTY.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload flops are reset too, so every output reads 0 straight after reset.
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    bus.occupancy = 2'd0;
    unique case (state_q)
      HALF:    bus.occupancy = 2'd1;
      FULL:    bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_cal      = main_q.cal;
  assign bus.out_rd       = main_q.rd;
  assign bus.out_wn       = main_q.wn;
  assign bus.out_memtoreg = main_q.memtoreg;
  assign bus.out_wb_data  = main_q.wb_data;
  // A stale payload must never reach the register file.
  assign bus.out_regwrite = main_q.regwrite & out_valid;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed vector table, hand sequences for reset/flush,
// then random handshakes checked against a queue-based reference model.
module tb_mem_wb_skid_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  mem_wb_skid_stage_if #(.DW(DW), .AW(AW)) bus ();
  mem_wb_skid_stage_if #(.DW(DW), .AW(AW)) bus0 ();

  mem_wb_skid_stage #(.DW(DW), .AW(AW), .ZERO_GATE(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  mem_wb_skid_stage #(.DW(DW), .AW(AW), .ZERO_GATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0)
  );

  assign bus0.in_valid    = bus.in_valid;
  assign bus0.in_cal      = bus.in_cal;
  assign bus0.in_rd       = bus.in_rd;
  assign bus0.in_wn       = bus.in_wn;
  assign bus0.in_regwrite = bus.in_regwrite;
  assign bus0.in_memtoreg = bus.in_memtoreg;
  assign bus0.out_ready   = bus.out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          r, f, iv;
    logic [DW-1:0] cal, rd;
    logic [AW-1:0] wn;
    logic          rw, m2r, ordy;
    logic          ev, erdy;
    logic [1:0]    eocc;
    logic [DW-1:0] ewb;
    logic          erw, erw0;
  } vec_t;

  typedef struct {
    logic [DW-1:0] cal, rd;
    logic [AW-1:0] wn;
    logic          rw, m2r;
  } beat_t;

  vec_t  vecs[$];
  beat_t mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, f, iv, input logic [DW-1:0] cal, rd,
                              input logic [AW-1:0] wn, input logic rw, m2r, ordy,
                              input logic ev, erdy, input logic [1:0] eocc,
                              input logic [DW-1:0] ewb, input logic erw, erw0);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.cal = cal; v.rd = rd; v.wn = wn;
    v.rw = rw; v.m2r = m2r; v.ordy = ordy;
    v.ev = ev; v.erdy = erdy; v.eocc = eocc; v.ewb = ewb; v.erw = erw; v.erw0 = erw0;
    return v;
  endfunction

  task automatic drive(input logic r, f, iv, input logic [DW-1:0] cal, rd,
                       input logic [AW-1:0] wn, input logic rw, m2r, ordy);
    @(negedge clk);
    rst             = r;
    flush           = f;
    bus.in_valid    = iv;
    bus.in_cal      = cal;
    bus.in_rd       = rd;
    bus.in_wn       = wn;
    bus.in_regwrite = rw;
    bus.in_memtoreg = m2r;
    bus.out_ready   = ordy;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"},    64'(bus.out_valid), 64'(0));
    check({tag, " occupancy"},    64'(bus.occupancy), 64'(0));
    check({tag, " out_cal"},      64'(bus.out_cal), 64'(0));
    check({tag, " out_rd"},       64'(bus.out_rd), 64'(0));
    check({tag, " out_wn"},       64'(bus.out_wn), 64'(0));
    check({tag, " out_regwrite"}, 64'(bus.out_regwrite), 64'(0));
    check({tag, " out_memtoreg"}, 64'(bus.out_memtoreg), 64'(0));
    check({tag, " out_wb_data"},  64'(bus.out_wb_data), 64'(0));
  endtask

  initial begin
    logic m2r;
    beat_t b, h;
    logic r, f, iv, ordy, in_fire, out_fire, clean;
    int ord_pct;

    // Reset for two cycles, then release.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, '0, '0, '0, 0, 0, 0);
      @(posedge clk); #1;
      check_all_zero($sformatf("reset%0d", i));
    end
    drive(0, 0, 0, '0, '0, '0, 0, 0, 0);
    @(posedge clk); #1;
    check("release in_ready",  64'(bus.in_ready), 64'(1));
    check("release out_valid", 64'(bus.out_valid), 64'(0));

    // Streaming with out_ready=1: one-cycle latency, occupancy stays 1.
    for (int i = 1; i <= 8; i++) begin
      m2r = logic'(i % 2);
      vecs.push_back(mk(0, 0, 1, m2r ? DW'(i + 'h100) : DW'(i), m2r ? DW'(i) : DW'(i + 'h200),
                        AW'(i), 1, m2r, 1, 1, 1, 2'd1, DW'(i), 1, 1));
    end
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 1, 0, 1, 2'd0, '0, 0, 0));
    // Stall: A, B fill the stage, C is refused, then A, B drain in order.
    vecs.push_back(mk(0, 0, 1, 'hA, 'h1A, 3, 1, 0, 0, 1, 1, 2'd1, 'hA, 1, 1));
    vecs.push_back(mk(0, 0, 1, 'hB, 'h1B, 4, 1, 0, 0, 1, 0, 2'd2, 'hA, 1, 1));
    vecs.push_back(mk(0, 0, 1, 'hC, 'h1C, 5, 1, 0, 0, 1, 0, 2'd2, 'hA, 1, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 1, 1, 1, 2'd1, 'hB, 1, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 1, 0, 1, 2'd0, '0, 0, 0));
    // Zero gate: wn=0 suppressed only when ZERO_GATE=1.
    vecs.push_back(mk(0, 0, 1, 'h55, 'h66, 0, 1, 0, 1, 1, 1, 2'd1, 'h55, 0, 1));
    vecs.push_back(mk(0, 0, 1, 'h77, 'h88, 7, 0, 1, 1, 1, 1, 2'd1, 'h88, 0, 0));
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 1, 0, 1, 2'd0, '0, 0, 0));
    // Flush while FULL with an incoming beat, from EMPTY, and from HALF with both fires.
    vecs.push_back(mk(0, 0, 1, 'h21, 0, 1, 1, 0, 0, 1, 1, 2'd1, 'h21, 1, 1));
    vecs.push_back(mk(0, 0, 1, 'h22, 0, 2, 1, 0, 0, 1, 0, 2'd2, 'h21, 1, 1));
    vecs.push_back(mk(0, 1, 1, 'h23, 0, 3, 1, 0, 1, 0, 1, 2'd0, '0, 0, 0));
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 1, 2'd0, '0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 'h24, 0, 4, 1, 0, 0, 0, 1, 2'd0, '0, 0, 0));
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, 1, 2'd0, '0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 'h30, 0, 5, 1, 0, 1, 1, 1, 2'd1, 'h30, 1, 1));
    vecs.push_back(mk(0, 1, 1, 'h31, 0, 6, 1, 0, 1, 0, 1, 2'd0, '0, 0, 0));
    vecs.push_back(mk(0, 0, 0, '0, '0, '0, 0, 0, 1, 0, 1, 2'd0, '0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].cal, vecs[i].rd, vecs[i].wn,
            vecs[i].rw, vecs[i].m2r, vecs[i].ordy);
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i),  64'(bus.out_valid), 64'(vecs[i].ev));
      check($sformatf("v%0d in_ready", i),   64'(bus.in_ready), 64'(vecs[i].erdy));
      check($sformatf("v%0d occupancy", i),  64'(bus.occupancy), 64'(vecs[i].eocc));
      check($sformatf("v%0d regwrite", i),   64'(bus.out_regwrite), 64'(vecs[i].erw));
      check($sformatf("v%0d regwrite_zg0", i), 64'(bus0.out_regwrite), 64'(vecs[i].erw0));
      if (vecs[i].ev)
        check($sformatf("v%0d wb_data", i), 64'(bus.out_wb_data), 64'(vecs[i].ewb));
    end

    // Reset while FULL, with out_ready toggling across the reset cycles.
    drive(0, 0, 1, 'h41, 'h51, 9, 1, 1, 0);
    drive(0, 0, 1, 'h42, 'h52, 10, 1, 0, 0);
    @(posedge clk); #1;
    check("pre-rst occupancy", 64'(bus.occupancy), 64'(2));
    drive(1, 0, 1, 'h43, 'h53, 11, 1, 1, 1);
    @(posedge clk); #1;
    check_all_zero("rst-full a");
    drive(1, 0, 1, 'h44, 'h54, 12, 1, 1, 0);
    @(posedge clk); #1;
    check_all_zero("rst-full b");
    check("rst-full in_ready", 64'(bus.in_ready), 64'(1));

    // Random handshakes against a FIFO model of at most two beats.
    drive(1, 0, 0, '0, '0, '0, 0, 0, 0);
    @(posedge clk); #1;
    mq.delete();
    clean = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ord_pct = ((cyc / 200) % 3 == 0) ? 90 : ((cyc / 200) % 3 == 1) ? 30 : 60;
      r    = ($urandom_range(0, 199) == 0);
      f    = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 99) < ord_pct);
      b.cal = DW'($urandom);
      b.rd  = DW'($urandom);
      b.wn  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      b.rw  = 1'($urandom);
      b.m2r = 1'($urandom);
      drive(r, f, iv, b.cal, b.rd, b.wn, b.rw, b.m2r, ordy);

      if (r) begin
        mq.delete();
        clean = 1'b1;
      end else begin
        in_fire  = iv && (mq.size() < 2);
        out_fire = (mq.size() > 0) && ordy;
        if (in_fire) clean = 1'b0;
        if (f) begin
          mq.delete();
        end else begin
          if (out_fire) void'(mq.pop_front());
          if (in_fire) mq.push_back(b);
        end
      end

      @(posedge clk); #1;
      check($sformatf("r%0d out_valid", cyc), 64'(bus.out_valid), 64'(mq.size() > 0));
      check($sformatf("r%0d in_ready", cyc),  64'(bus.in_ready), 64'(mq.size() < 2));
      check($sformatf("r%0d occupancy", cyc), 64'(bus.occupancy), 64'(mq.size()));
      if (mq.size() > 0) begin
        h = mq[0];
        check($sformatf("r%0d out_cal", cyc),      64'(bus.out_cal), 64'(h.cal));
        check($sformatf("r%0d out_rd", cyc),       64'(bus.out_rd), 64'(h.rd));
        check($sformatf("r%0d out_wn", cyc),       64'(bus.out_wn), 64'(h.wn));
        check($sformatf("r%0d out_memtoreg", cyc), 64'(bus.out_memtoreg), 64'(h.m2r));
        check($sformatf("r%0d out_wb_data", cyc),  64'(bus.out_wb_data),
              64'(h.m2r ? h.rd : h.cal));
        check($sformatf("r%0d out_regwrite", cyc), 64'(bus.out_regwrite),
              64'(h.rw && (h.wn != 0)));
        check($sformatf("r%0d regwrite_zg0", cyc), 64'(bus0.out_regwrite), 64'(h.rw));
      end else begin
        check($sformatf("r%0d idle regwrite", cyc), 64'(bus.out_regwrite), 64'(0));
        check($sformatf("r%0d idle regwrite_zg0", cyc), 64'(bus0.out_regwrite), 64'(0));
        if (clean)
          check($sformatf("r%0d clean wb_data", cyc), 64'(bus.out_wb_data), 64'(0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
